spi_reg_ctrl: RTL and testbench

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

---
 rtl/spi_reg_ctrl_pkg.sv | 28 ++
 rtl/spi_reg_ctrl_sync2.sv | 27 ++
 rtl/spi_reg_ctrl.sv | 144 ++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_ctrl_pkg.sv
// Shared types and constants for the SPI register controller.
//   state_t      : controller FSM states
//   ADDR_*       : register map addresses
//   MAX_ADDR     : highest writable address
//   FRAME_BITS   : bits in a valid frame (R/W + 7-bit address + 8-bit data)
//   SYNC_DEPTH   : flops in each input synchronizer
//   CNT_SAT      : bit-counter saturation value (one past a full frame)
package spi_reg_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [6:0] ADDR_OUT_7_0   = 7'h00;
    localparam logic [6:0] ADDR_OUT_15_8  = 7'h01;
    localparam logic [6:0] ADDR_PWM_7_0   = 7'h02;
    localparam logic [6:0] ADDR_PWM_15_8  = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;
    localparam logic [6:0] MAX_ADDR       = 7'h04;

    localparam int         FRAME_BITS     = 16;
    localparam int         SYNC_DEPTH     = 2;
    localparam int         CNT_W          = 5;
    localparam logic [4:0] CNT_SAT        = 5'd17;

endpackage

// File: rtl/spi_reg_ctrl_sync2.sv
// sync2: flop-chain synchronizer for one asynchronous input into clk.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears the chain to 0
//   d     : asynchronous input
//   q     : synchronized output
module sync2
    import spi_reg_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_DEPTH-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_DEPTH-2:0], d};
        end
    end

    assign q = r_chain[SYNC_DEPTH-1];

endmodule

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI (mode 0, MSB first) write-only register port, 16-bit frames
// {R/W, addr[6:0], data[7:0]}, driving five 8-bit control registers.
//   clk, rst_n        : system clock, async active-low reset
//   sclk, copi, ncs   : SPI pins, asynchronous to clk
//   en_reg_out_*      : output-enable bits
//   en_reg_pwm_*      : PWM-mode select bits
//   pwm_duty_cycle    : PWM duty value
//   wr_done           : one-clk pulse per committed write
//
// state  | meaning
// IDLE   | waiting for ncs falling edge
// SHIFT  | shifting copi on sclk rising edges until ncs rises
// COMMIT | valid write frame: update addressed register, pulse wr_done
module spi_reg_ctrl
    import spi_reg_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_done
);

    logic             w_sclk_s;
    logic             w_copi_s;
    logic             w_ncs_s;
    logic             r_sclk_d;
    logic             r_ncs_d;
    logic             w_sclk_rise;
    logic             w_ncs_fall;
    logic             w_ncs_rise;
    logic             w_frame_ok;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_shift;
    logic [7:0]       r_out_lo;
    logic [7:0]       r_out_hi;
    logic [7:0]       r_pwm_lo;
    logic [7:0]       r_pwm_hi;
    logic [7:0]       r_duty;
    logic             r_wr_done;

    sync2 u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(sclk), .q(w_sclk_s));
    sync2 u_sync_copi (.clk(clk), .rst_n(rst_n), .d(copi), .q(w_copi_s));
    sync2 u_sync_ncs  (.clk(clk), .rst_n(rst_n), .d(ncs),  .q(w_ncs_s));

    // Third copy for edge detection. Resetting to 0 means a chip select held
    // low across reset release never looks like a falling edge, so a frame
    // interrupted by reset cannot be picked up halfway through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_d <= 1'b0;
            r_ncs_d  <= 1'b0;
        end else begin
            r_sclk_d <= w_sclk_s;
            r_ncs_d  <= w_ncs_s;
        end
    end

    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_ncs_fall  = ~w_ncs_s & r_ncs_d;
    assign w_ncs_rise  = w_ncs_s & ~r_ncs_d;

    assign w_frame_ok  = (r_cnt == CNT_W'(FRAME_BITS)) && r_shift[15] &&
                         (r_shift[14:8] <= MAX_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_ncs_fall) w_state_nxt = ST_SHIFT;
            ST_SHIFT:  if (w_ncs_rise) w_state_nxt = w_frame_ok ? ST_COMMIT : ST_IDLE;
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_shift   <= '0;
            r_out_lo  <= 8'h00;
            r_out_hi  <= 8'h00;
            r_pwm_lo  <= 8'h00;
            r_pwm_hi  <= 8'h00;
            r_duty    <= 8'h00;
            r_wr_done <= 1'b0;
        end else begin
            r_wr_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_ncs_fall) begin
                        r_cnt   <= '0;
                        r_shift <= '0;
                    end
                end
                ST_SHIFT: begin
                    // The closing ncs edge wins over a coincident sclk edge so
                    // the frame is judged on what was shifted before it.
                    if (!w_ncs_rise && w_sclk_rise) begin
                        r_shift <= {r_shift[14:0], w_copi_s};
                        if (r_cnt != CNT_SAT) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    r_wr_done <= 1'b1;
                    case (r_shift[14:8])
                        ADDR_OUT_7_0:  r_out_lo <= r_shift[7:0];
                        ADDR_OUT_15_8: r_out_hi <= r_shift[7:0];
                        ADDR_PWM_7_0:  r_pwm_lo <= r_shift[7:0];
                        ADDR_PWM_15_8: r_pwm_hi <= r_shift[7:0];
                        ADDR_PWM_DUTY: r_duty   <= r_shift[7:0];
                        default:       ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign en_reg_out_7_0  = r_out_lo;
    assign en_reg_out_15_8 = r_out_hi;
    assign en_reg_pwm_7_0  = r_pwm_lo;
    assign en_reg_pwm_15_8 = r_pwm_hi;
    assign pwm_duty_cycle  = r_duty;
    assign wr_done         = r_wr_done;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: directed scenarios plus randomized
// frames compared against a register-map model.
module tb_spi_reg_ctrl;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_done;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    logic [7:0] m_regs [5];

    spi_reg_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sclk            (sclk),
        .copi            (copi),
        .ncs             (ncs),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .wr_done         (wr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (wr_done === 1'b1) pulses++;

    function automatic logic [39:0] dut_regs();
        return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0,
                en_reg_out_15_8, en_reg_out_7_0};
    endfunction

    function automatic logic [39:0] model_regs();
        return {m_regs[4], m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
    endfunction

    // A frame is a write only if exactly 16 bits, R/W set and address in map.
    function automatic bit model_apply(input logic [31:0] f, input int n);
        int addr;
        if (n != 16) return 1'b0;
        if (f[15] != 1'b1) return 1'b0;
        addr = int'(f[14:8]);
        if (addr > 4) return 1'b0;
        m_regs[addr] = f[7:0];
        return 1'b1;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drop ncs and clock out the n low bits of f MSB first; ncs stays low.
    task automatic send_bits(input logic [31:0] f, input int n);
        ncs = 1'b0;
        wait_clk(5);
        for (int i = n - 1; i >= 0; i--) begin
            copi = f[i];
            wait_clk(5);
            sclk = 1'b1;
            wait_clk(5);
            sclk = 1'b0;
        end
        wait_clk(5);
    endtask

    // Raise ncs and observe 8 cycles: first cycle wr_done is seen, pulse count.
    task automatic close_frame(input int p0, output int lat, output int dp);
        ncs = 1'b1;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            wait_clk(1);
            if (wr_done === 1'b1 && lat == 0) lat = k;
        end
        dp = pulses - p0;
    endtask

    task automatic run_frame(input logic [31:0] f, input int n,
                             output int lat, output int dp);
        int p0;
        p0 = pulses;
        send_bits(f, n);
        close_frame(p0, lat, dp);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
        model_reset();
        wait_clk(3);
        checks++;
        if (dut_regs() !== model_regs()) begin
            errors++;
            $display("FAIL reset_regs: got %h expected %h", dut_regs(), model_regs());
        end
        checks++;
        if (wr_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_wr_done: got %b expected 0", wr_done);
        end
        rst_n = 1'b1;
        wait_clk(5);
    endtask

    task automatic test_single_write();
        int lat, dp;
        void'(model_apply(32'h8055, 16));
        run_frame(32'h8055, 16, lat, dp);
        checks++;
        if (dp !== 1) begin
            errors++;
            $display("FAIL single_pulses: got %0d expected 1", dp);
        end
        checks++;
        if (dut_regs() !== model_regs()) begin
            errors++;
            $display("FAIL single_regs: got %h expected %h", dut_regs(), model_regs());
        end
    endtask

    task automatic test_duty();
        int lat, dp;
        logic [31:0] frames [2];
        frames[0] = 32'h8480;
        frames[1] = 32'h84FF;
        for (int i = 0; i < 2; i++) begin
            void'(model_apply(frames[i], 16));
            run_frame(frames[i], 16, lat, dp);
            checks++;
            if (!(lat >= 1 && lat <= 5)) begin
                errors++;
                $display("FAIL duty_latency: got %0d cycles expected 1..5", lat);
            end
            checks++;
            if (pwm_duty_cycle !== m_regs[4]) begin
                errors++;
                $display("FAIL duty_value: got %h expected %h", pwm_duty_cycle, m_regs[4]);
            end
        end
    endtask

    task automatic test_reject();
        int lat, dp;
        logic [31:0] frames [4];
        int          lens   [4];
        frames[0] = 32'h00AA;   lens[0] = 16;
        frames[1] = 32'h85AA;   lens[1] = 16;
        frames[2] = 32'h081F;   lens[2] = 12;
        frames[3] = 32'h103E0;  lens[3] = 17;
        for (int i = 0; i < 4; i++) begin
            void'(model_apply(frames[i], lens[i]));
            run_frame(frames[i], lens[i], lat, dp);
            checks++;
            if (dp !== 0) begin
                errors++;
                $display("FAIL reject_pulses[%0d]: got %0d expected 0", i, dp);
            end
            checks++;
            if (dut_regs() !== model_regs()) begin
                errors++;
                $display("FAIL reject_regs[%0d]: got %h expected %h", i, dut_regs(), model_regs());
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int lat, dp, p0;
        send_bits(32'h0083, 8);
        rst_n = 1'b0;
        model_reset();
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(2);
        checks++;
        if (dut_regs() !== model_regs()) begin
            errors++;
            $display("FAIL midrst_regs: got %h expected %h", dut_regs(), model_regs());
        end
        p0 = pulses;
        send_bits(32'h0033, 8);
        close_frame(p0, lat, dp);
        checks++;
        if (dp !== 0 || en_reg_pwm_15_8 !== 8'h00) begin
            errors++;
            $display("FAIL midrst_discard: pulses %0d reg %h expected 0 and 00", dp, en_reg_pwm_15_8);
        end
        void'(model_apply(32'h8333, 16));
        run_frame(32'h8333, 16, lat, dp);
        checks++;
        if (dp !== 1 || en_reg_pwm_15_8 !== 8'h33) begin
            errors++;
            $display("FAIL midrst_refresh: pulses %0d reg %h expected 1 and 33", dp, en_reg_pwm_15_8);
        end
    endtask

    task automatic test_back_to_back();
        int lat, dp, p0;
        p0 = pulses;
        void'(model_apply(32'h8201, 16));
        void'(model_apply(32'h8302, 16));
        send_bits(32'h8201, 16);
        ncs = 1'b1;
        wait_clk(4);
        send_bits(32'h8302, 16);
        close_frame(p0, lat, dp);
        checks++;
        if (dp !== 2) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d expected 2", dp);
        end
        checks++;
        if (dut_regs() !== model_regs()) begin
            errors++;
            $display("FAIL b2b_regs: got %h expected %h", dut_regs(), model_regs());
        end
    endtask

    task automatic test_random();
        int lat, dp, n, pick;
        logic [31:0] f;
        bit valid;
        for (int it = 0; it < 40; it++) begin
            pick = int'($urandom_range(0, 9));
            n = (pick < 7) ? 16 : (pick == 7) ? int'($urandom_range(1, 15))
                                              : int'($urandom_range(17, 20));
            f = $urandom;
            if (n == 16) begin
                f = {16'h0, ($urandom_range(0, 4) != 0), 7'($urandom_range(0, 7)), 8'($urandom)};
            end else begin
                f = f & ((32'h1 << n) - 32'h1);
            end
            // sclk activity with ncs deasserted must not disturb anything
            if ($urandom_range(0, 2) == 0) begin
                for (int t = 0; t < 3; t++) begin
                    copi = 1'($urandom);
                    sclk = 1'b1;
                    wait_clk(5);
                    sclk = 1'b0;
                    wait_clk(5);
                end
            end
            valid = model_apply(f, n);
            run_frame(f, n, lat, dp);
            checks++;
            if (dp !== (valid ? 1 : 0)) begin
                errors++;
                $display("FAIL rand_pulses[%0d] f=%h n=%0d: got %0d expected %0d", it, f, n, dp, valid ? 1 : 0);
            end
            if (valid) begin
                checks++;
                if (!(lat >= 1 && lat <= 5)) begin
                    errors++;
                    $display("FAIL rand_latency[%0d]: got %0d cycles expected 1..5", it, lat);
                end
            end
            checks++;
            if (dut_regs() !== model_regs()) begin
                errors++;
                $display("FAIL rand_regs[%0d] f=%h n=%0d: got %h expected %h", it, f, n, dut_regs(), model_regs());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_duty();
        test_reject();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
